// File: rtl/bsg_cache_dma_wb_pkg.sv
// Shared command/state types for the bsg_cache DMA engine with write-back buffer.
package bsg_cache_dma_wb_pkg;

   typedef enum logic [2:0] {
      e_dma_nop,
      e_dma_send_fill_addr,
      e_dma_send_evict_addr,
      e_dma_get_fill_data,
      e_dma_send_evict_data
   } bsg_cache_dma_cmd_e;

   typedef enum logic [1:0] {
      e_idle,
      e_fill,
      e_evict_copy
   } dma_wb_state_e;

   // Index width that never collapses below one bit.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_cache_dma_wb_buf.sv
// Victim buffer: filled by the evict copy, drained to DMA independently of the FSM.
module bsg_cache_dma_wb_buf #(
   parameter int els_p    = 4,
   parameter int width_p  = 64,
   parameter int lg_els_p = 2
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                w_v_i,
   input  logic [lg_els_p-1:0] w_idx_i,
   input  logic [width_p-1:0]  w_data_i,
   input  logic                commit_i,
   output logic                v_o,
   output logic [width_p-1:0]  data_o,
   input  logic                yumi_i
);

   localparam logic [lg_els_p-1:0] last_idx_lp = lg_els_p'(els_p - 1);

   logic [width_p-1:0]  mem_r [els_p];
   logic                valid_q, valid_d;
   logic [lg_els_p-1:0] rd_ptr_q, rd_ptr_d;

   // NOTE: storage is not reset; valid_q alone says whether it holds anything.
   always_ff @(posedge clk_i) begin
      if (w_v_i)
         mem_r[w_idx_i] <= w_data_i;
   end

   always_comb begin
      valid_d  = valid_q;
      rd_ptr_d = rd_ptr_q;
      if (valid_q && yumi_i) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         if (rd_ptr_q == last_idx_lp) begin
            valid_d  = 1'b0;
            rd_ptr_d = '0;
         end
      end
      if (commit_i) begin
         valid_d  = 1'b1;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q  <= 1'b0;
         rd_ptr_q <= '0;
      end else begin
         valid_q  <= valid_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   assign v_o    = valid_q;
   assign data_o = mem_r[rd_ptr_q];

endmodule

// File: rtl/bsg_cache_dma_wb.sv
// DMA engine for bsg_cache: fill (optionally critical-word-first) and evict through a
// write-back buffer so the victim drains while the refill of the same set proceeds.
module bsg_cache_dma_wb
   import bsg_cache_dma_wb_pkg::*;
#(
   parameter int addr_width_p          = 32,
   parameter int data_width_p          = 32,
   parameter int block_size_in_words_p = 8,
   parameter int sets_p                = 4,
   parameter int ways_p                = 2,
   parameter int dma_data_width_p      = data_width_p,
   parameter int crit_word_first_p     = 0,
   parameter int word_tracking_p       = 0,
   localparam int burst_len_lp     = block_size_in_words_p * data_width_p / dma_data_width_p,
   localparam int lg_burst_lp      = safe_clog2(burst_len_lp),
   localparam int lg_ways_lp       = safe_clog2(ways_p),
   localparam int lg_sets_lp       = safe_clog2(sets_p),
   localparam int dma_bytes_lp     = dma_data_width_p / 8,
   localparam int dm_addr_width_lp = lg_sets_lp + lg_burst_lp,
   localparam int dm_mask_width_lp = ways_p * dma_bytes_lp,
   localparam int pkt_width_lp     = 1 + block_size_in_words_p + addr_width_p
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  bsg_cache_dma_cmd_e                   dma_cmd_i,
   input  logic [lg_ways_lp-1:0]                dma_way_i,
   input  logic [addr_width_p-1:0]              dma_addr_i,
   input  logic [block_size_in_words_p-1:0]     track_mask_i,
   output logic                                 done_o,
   output logic [data_width_p-1:0]              snoop_word_o,
   output logic [pkt_width_lp-1:0]              dma_pkt_o,
   output logic                                 dma_pkt_v_o,
   input  logic                                 dma_pkt_yumi_i,
   input  logic [dma_data_width_p-1:0]          dma_data_i,
   input  logic                                 dma_data_v_i,
   output logic                                 dma_data_ready_o,
   output logic [dma_data_width_p-1:0]          dma_data_o,
   output logic                                 dma_data_v_o,
   input  logic                                 dma_data_yumi_i,
   output logic                                 data_mem_v_o,
   output logic                                 data_mem_w_o,
   output logic [dm_addr_width_lp-1:0]          data_mem_addr_o,
   output logic [dm_mask_width_lp-1:0]          data_mem_w_mask_o,
   output logic [ways_p*dma_data_width_p-1:0]   data_mem_data_o,
   input  logic [ways_p*dma_data_width_p-1:0]   data_mem_data_i,
   output logic                                 dma_evict_o
);

   localparam int lg_data_bytes_lp  = $clog2(data_width_p / 8);
   localparam int lg_dma_bytes_lp   = $clog2(dma_bytes_lp);
   localparam int lg_block_bytes_lp = $clog2(block_size_in_words_p * data_width_p / 8);
   localparam int words_per_beat_lp = dma_data_width_p / data_width_p;
   localparam int lg_wpb_lp         = safe_clog2(words_per_beat_lp);

   localparam logic [lg_burst_lp:0] cnt_last_lp  = (lg_burst_lp + 1)'(burst_len_lp - 1);
   localparam logic [lg_burst_lp:0] cnt_burst_lp = (lg_burst_lp + 1)'(burst_len_lp);

   dma_wb_state_e             state_q, state_d;
   logic [lg_burst_lp:0]      cnt_q, cnt_d;
   logic [lg_burst_lp-1:0]    start_q, start_d;
   logic [data_width_p-1:0]   snoop_q, snoop_d;

   logic [lg_sets_lp-1:0]       set_idx;
   logic [lg_burst_lp-1:0]      crit_beat, fill_idx;
   logic [lg_wpb_lp-1:0]        crit_word;
   logic [addr_width_p-1:0]     blk_addr, beat_addr;
   logic [data_width_p-1:0]     fill_word;
   logic [dma_data_width_p-1:0] rd_beat;
   logic [dm_mask_width_lp-1:0] way_mask;

   logic                        pkt_wnr;
   logic [block_size_in_words_p-1:0] pkt_mask;
   logic [addr_width_p-1:0]     pkt_addr;

   logic                        buf_w_v, buf_commit, wb_valid;
   logic [lg_burst_lp-1:0]      buf_w_idx;

   always_comb begin
      set_idx   = (sets_p == 1) ? '0 : dma_addr_i[lg_block_bytes_lp +: lg_sets_lp];
      crit_beat = (burst_len_lp == 1) ? '0 : dma_addr_i[lg_dma_bytes_lp +: lg_burst_lp];
      crit_word = (words_per_beat_lp == 1) ? '0 : dma_addr_i[lg_data_bytes_lp +: lg_wpb_lp];
      fill_idx  = (burst_len_lp == 1) ? '0 : start_q + cnt_q[lg_burst_lp-1:0];

      blk_addr  = dma_addr_i;
      beat_addr = dma_addr_i;
      for (int i = 0; i < lg_block_bytes_lp; i++) blk_addr[i] = 1'b0;
      for (int i = 0; i < lg_dma_bytes_lp; i++) beat_addr[i] = 1'b0;

      fill_word = dma_data_i[data_width_p-1:0];
      for (int i = 0; i < words_per_beat_lp; i++)
         if (crit_word == lg_wpb_lp'(i)) fill_word = dma_data_i[i*data_width_p +: data_width_p];

      rd_beat  = data_mem_data_i[dma_data_width_p-1:0];
      way_mask = '0;
      for (int w = 0; w < ways_p; w++) begin
         if (dma_way_i == lg_ways_lp'(w)) begin
            rd_beat = data_mem_data_i[w*dma_data_width_p +: dma_data_width_p];
            way_mask[w*dma_bytes_lp +: dma_bytes_lp] = '1;
         end
      end
   end

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      start_d           = start_q;
      snoop_d           = snoop_q;
      done_o            = 1'b0;
      dma_pkt_v_o       = 1'b0;
      pkt_wnr           = 1'b0;
      pkt_mask          = '1;
      pkt_addr          = blk_addr;
      dma_data_ready_o  = 1'b0;
      data_mem_v_o      = 1'b0;
      data_mem_w_o      = 1'b0;
      data_mem_addr_o   = {set_idx, fill_idx};
      data_mem_w_mask_o = '0;
      data_mem_data_o   = {ways_p{dma_data_i}};
      buf_w_v           = 1'b0;
      buf_w_idx         = lg_burst_lp'(cnt_q - 1'b1);
      buf_commit        = 1'b0;

      unique case (state_q)
         e_idle: begin
            unique case (dma_cmd_i)
               e_dma_send_fill_addr: begin
                  dma_pkt_v_o = 1'b1;
                  pkt_addr    = (crit_word_first_p != 0) ? beat_addr : blk_addr;
                  done_o      = dma_pkt_yumi_i;
               end
               e_dma_send_evict_addr: begin
                  dma_pkt_v_o = 1'b1;
                  pkt_wnr     = 1'b1;
                  pkt_mask    = (word_tracking_p != 0) ? track_mask_i : '1;
                  done_o      = dma_pkt_yumi_i;
               end
               e_dma_get_fill_data: begin
                  start_d = (crit_word_first_p != 0) ? crit_beat : '0;
                  cnt_d   = '0;
                  state_d = e_fill;
               end
               e_dma_send_evict_data: begin
                  // A full buffer means the previous victim is still draining.
                  if (!wb_valid) begin
                     cnt_d   = '0;
                     state_d = e_evict_copy;
                  end
               end
               default: ;
            endcase
         end

         e_fill: begin
            dma_data_ready_o = 1'b1;
            if (dma_data_v_i) begin
               data_mem_v_o      = 1'b1;
               data_mem_w_o      = 1'b1;
               data_mem_w_mask_o = way_mask;
               if (fill_idx == crit_beat) snoop_d = fill_word;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == cnt_last_lp) begin
                  done_o  = 1'b1;
                  state_d = e_idle;
               end
            end
         end

         e_evict_copy: begin
            // Read beat cnt now; its data lands one cycle later in entry cnt-1.
            if (cnt_q < cnt_burst_lp) begin
               data_mem_v_o    = 1'b1;
               data_mem_addr_o = {set_idx, cnt_q[lg_burst_lp-1:0]};
            end
            buf_w_v = (cnt_q != '0);
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == cnt_burst_lp) begin
               done_o     = 1'b1;
               buf_commit = 1'b1;
               state_d    = e_idle;
            end
         end

         default: state_d = e_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= e_idle;
         cnt_q   <= '0;
         start_q <= '0;
         snoop_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         snoop_q <= snoop_d;
      end
   end

   bsg_cache_dma_wb_buf #(
      .els_p    (burst_len_lp),
      .width_p  (dma_data_width_p),
      .lg_els_p (lg_burst_lp)
   ) wb_buf (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .w_v_i    (buf_w_v),
      .w_idx_i  (buf_w_idx),
      .w_data_i (rd_beat),
      .commit_i (buf_commit),
      .v_o      (wb_valid),
      .data_o   (dma_data_o),
      .yumi_i   (dma_data_yumi_i)
   );

   assign dma_data_v_o = wb_valid;
   assign dma_evict_o  = (state_q == e_evict_copy) || wb_valid;
   assign snoop_word_o = snoop_q;
   assign dma_pkt_o    = {pkt_wnr, pkt_mask, pkt_addr};

endmodule
